dram_page_ctrl: RTL and testbench
=================================

# dram_page_ctrl

Open-page DRAM command sequencer between the system bus slave side and the off-chip DRAM pins (`DRAM_CSn/WEn/RASn/CASn/A/D/Q/valid`). It accepts one word read or write at a time and issues PRECHARGE, ACTIVATE and READ/WRITE commands with programmable spacing. It tracks the single open row, returns read data on `DRAM_valid`, and optionally closes an idle page after a timeout.

## Interface
- `T_RP`, default 5: cycles from PRECHARGE to next ACTIVATE (≥1).
- `T_RCD`, default 5: cycles from ACTIVATE to READ/WRITE (≥1).
- `T_WR`, default 5: cycles from WRITE to write response (≥1).
- `RD_TIMEOUT`, default 64: cycles to wait for `DRAM_valid` after READ before an error response (≥1).
- `IDLE_CLOSE`, default 0: idle cycles with a row open before an autonomous PRECHARGE; 0 disables.

Ports:
- `clk` in 1: sole clock.
- `rstn` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 21: word address; row = `[20:10]`, column = `[9:0]`.
- `req_wstrb` in 4: byte enables, write only.
- `req_wdata` in 32: write data.
- `resp_valid` out 1: one-cycle completion pulse. There is no backpressure.
- `resp_rdata` out 32: read data, valid with `resp_valid`.
- `resp_err` out 1: read timeout flag, valid with `resp_valid`.
- `DRAM_CSn` out 1: chip select.
- `DRAM_RASn` out 1: row strobe.
- `DRAM_CASn` out 1: column strobe.
- `DRAM_WEn` out 4: per-byte write enables, active low.
- `DRAM_A` out 11: multiplexed row/column address.
- `DRAM_D` out 32: write data.
- `DRAM_Q` in 32: read data.
- `DRAM_valid` in 1: read data valid.

## Operation
- All outputs are registered (Moore, decoded from the state).
- Command encoding, each driven for exactly one cycle:
  - NOP: CSn=0, RASn=1, CASn=1, WEn=F.
  - PRE: RASn=0, CASn=1, WEn=0.
  - ACT: RASn=0, CASn=1, WEn=F, A=row.
  - RD: RASn=1, CASn=0, WEn=F, A={1'b0,col}.
  - WR: RASn=1, CASn=0, WEn=~wstrb, A={1'b0,col}, D=wdata.
- States: IDLE, PRE, PRE_W, ACT, ACT_W, RD, RD_W, WR, WR_W, RESP.
- `req_ready` = 1 only in IDLE. On accept, latch write flag, address, strobe and data.
- Dispatch from IDLE on accept:
  - `wstrb==0` write → RESP directly; no DRAM command is issued.
  - No row open → ACT.
  - Open row == req row → RD or WR (page hit).
  - Open row != req row → PRE.
- PRE → PRE_W for T_RP-1 cycles → ACT. ACT records the open row, then → ACT_W for T_RCD-1 cycles → RD/WR. With a wait count of 0, the W state is skipped.
- Read path:
  - RD → RD_W, which samples `DRAM_valid` from the cycle after RD.
  - On the first valid: capture `DRAM_Q` → RESP with err=0.
  - After RD_TIMEOUT cycles without valid: RESP with rdata=0, err=1. The row stays open.
- Write path: WR → WR_W for T_WR-1 cycles → RESP.
- RESP: `resp_valid`=1 for one cycle → IDLE. `resp_rdata`/`resp_err` hold until the next RESP.
- Idle close (IDLE_CLOSE>0):
  - The counter runs in IDLE while a row is open.
  - At IDLE_CLOSE it goes → PRE with the close flag set. After PRE_W it returns to IDLE with no row open and no response.
  - A request arriving in the same cycle the counter expires wins: it is accepted and the close is cancelled.
- A late `DRAM_valid` outside RD_W is ignored.

## Timing
- Reset values:
  - Control: `req_ready`=0 in reset, then 1 in IDLE; `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
  - DRAM pins: `DRAM_CSn`=1, RASn=1, CASn=1, WEn=F, A=0, D=0.
  - Internal: no row open.
- Reset asserted mid-sequence aborts immediately; no response is produced.
- Accept at cycle T. Command cycles:
  - Page hit: RD/WR at T+1.
  - Closed: ACT at T+1, RD/WR at T+1+T_RCD.
  - Miss: PRE at T+1, ACT at T+1+T_RP, RD/WR at T+1+T_RP+T_RCD.
- Read: if `DRAM_valid` is first high at cycle V, `resp_valid` is at V+1.
- Write: WR at cycle W gives `resp_valid` at W+T_WR.
- Next accept is possible the cycle after RESP.
- Min turnaround, page-hit write with T_WR=1: 3 cycles per request.

## Test plan
- Reset, then a read of addr 0x00405 (row 1, col 5), with DRAM asserting valid 3 cycles after RD with Q=0xDEADBEEF:
  - ACT A=1 at T+1, RD A=5 at T+6.
  - resp_valid at T+10 with rdata DEADBEEF, err=0.
- Write 0x00406, wstrb=4'b0101, data 0x11223344 after the above (page hit):
  - WR at T+1 with WEn=4'b1010, D=11223344, A=6.
  - resp_valid at T+6.
- Read 0x00C00 with row 1 open (miss):
  - PRE at T+1, ACT A=3 at T+6, RD A=0 at T+11.
- Read with DRAM never asserting valid, RD_TIMEOUT=64:
  - resp_valid with err=1, rdata=0, 64 cycles after entering RD_W.
  - The next read to the same row is a page hit.
- IDLE_CLOSE=8:
  - Idle with row open → PRE on the 9th idle cycle, no resp_valid; the next request issues ACT.
  - A request in the expiry cycle → no PRE, page hit.
- Write with wstrb=0 → no CSn/RASn/CASn activity, resp_valid at T+1.
- rstn low during ACT_W → all DRAM pins return to reset values immediately, no resp_valid, next request issues ACT.

Source files
------------

// File: rtl/dram_page_ctrl.sv
// dram_page_ctrl: open-page DRAM command sequencer for single-word bus accesses.
// Accepts one read or write at a time, issues PRECHARGE / ACTIVATE / READ / WRITE
// with programmable spacing, tracks the single open row, and can close an idle
// page after IDLE_CLOSE cycles (0 disables).
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_write/addr/wstrb/wdata request payload; row = addr[20:10], col = addr[9:0]
//   resp_valid/rdata/err       one-cycle completion pulse; rdata/err hold until next
//   DRAM_CSn/RASn/CASn/WEn/A/D command pins to the device (all registered)
//   DRAM_Q/DRAM_valid          read data returned by the device
module dram_page_ctrl #(
  parameter int unsigned T_RP       = 5,
  parameter int unsigned T_RCD      = 5,
  parameter int unsigned T_WR       = 5,
  parameter int unsigned RD_TIMEOUT = 64,
  parameter int unsigned IDLE_CLOSE = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [20:0] req_addr,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        DRAM_CSn,
  output logic        DRAM_RASn,
  output logic        DRAM_CASn,
  output logic [3:0]  DRAM_WEn,
  output logic [10:0] DRAM_A,
  output logic [31:0] DRAM_D,
  input  logic [31:0] DRAM_Q,
  input  logic        DRAM_valid
);

  localparam int unsigned CW    = 16;
  localparam int unsigned ROW_W = 11;
  localparam int unsigned COL_W = 10;
  localparam int unsigned AW    = 21;
  localparam int unsigned DW    = 32;

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_PRE_W, S_ACT, S_ACT_W, S_RD, S_RD_W, S_WR, S_WR_W, S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic               row_open_q, row_open_d;
  logic [ROW_W-1:0]   open_row_q, open_row_d;
  logic               close_q, close_d;
  logic [DW-1:0]      rdata_d;
  logic               err_d;

  logic               csn_d, rasn_d, casn_d;
  logic [3:0]         wen_d;
  logic [ROW_W-1:0]   a_d;
  logic [DW-1:0]      d_d;

  // Next-state, request latching, row tracking and response data.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wstrb_d    = wstrb_q;
    wdata_d    = wdata_q;
    row_open_d = row_open_q;
    open_row_d = open_row_q;
    close_d    = close_q;
    rdata_d    = resp_rdata;
    err_d      = resp_err;

    case (state_q)
      S_IDLE: begin
        // A request always beats the idle-close timer, even in its expiry cycle.
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wstrb_d = req_wstrb;
          wdata_d = req_wdata;
          if (req_write && (req_wstrb == 4'b0000)) begin
            state_d = S_RESP;
            rdata_d = '0;
            err_d   = 1'b0;
          end else if (!row_open_q) begin
            state_d = S_ACT;
          end else if (open_row_q == req_addr[AW-1:COL_W]) begin
            state_d = req_write ? S_WR : S_RD;
          end else begin
            state_d = S_PRE;
          end
        end else if ((IDLE_CLOSE != 0) && row_open_q) begin
          if (cnt_q == CW'(IDLE_CLOSE - 1)) begin
            state_d = S_PRE;
            close_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_PRE: begin
        row_open_d = 1'b0;
        if (T_RP > 1) begin
          state_d = S_PRE_W;
        end else if (close_q) begin
          state_d = S_IDLE;
          close_d = 1'b0;
        end else begin
          state_d = S_ACT;
        end
      end

      S_PRE_W: begin
        if (cnt_q == CW'(T_RP - 2)) begin
          if (close_q) begin
            state_d = S_IDLE;
            close_d = 1'b0;
          end else begin
            state_d = S_ACT;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_ACT: begin
        row_open_d = 1'b1;
        open_row_d = addr_q[AW-1:COL_W];
        if (T_RCD > 1) state_d = S_ACT_W;
        else           state_d = wr_q ? S_WR : S_RD;
      end

      S_ACT_W: begin
        if (cnt_q == CW'(T_RCD - 2)) state_d = wr_q ? S_WR : S_RD;
        else                         cnt_d = cnt_q + CW'(1);
      end

      S_RD: state_d = S_RD_W;

      // First valid wins; the timeout leaves the row open.
      S_RD_W: begin
        if (DRAM_valid) begin
          state_d = S_RESP;
          rdata_d = DRAM_Q;
          err_d   = 1'b0;
        end else if (cnt_q == CW'(RD_TIMEOUT - 1)) begin
          state_d = S_RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_WR: begin
        if (T_WR > 1) begin
          state_d = S_WR_W;
        end else begin
          state_d = S_RESP;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end

      S_WR_W: begin
        if (cnt_q == CW'(T_WR - 2)) begin
          state_d = S_RESP;
          rdata_d = '0;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_RESP: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // Pin decode from the upcoming state so the registered pins line up with it.
  always_comb begin
    csn_d  = 1'b0;
    rasn_d = 1'b1;
    casn_d = 1'b1;
    wen_d  = 4'hF;
    a_d    = '0;
    d_d    = '0;
    case (state_d)
      S_PRE: begin
        rasn_d = 1'b0;
        wen_d  = 4'h0;
      end
      S_ACT: begin
        rasn_d = 1'b0;
        a_d    = addr_d[AW-1:COL_W];
      end
      S_RD: begin
        casn_d = 1'b0;
        a_d    = {1'b0, addr_d[COL_W-1:0]};
      end
      S_WR: begin
        casn_d = 1'b0;
        wen_d  = ~wstrb_d;
        a_d    = {1'b0, addr_d[COL_W-1:0]};
        d_d    = wdata_d;
      end
      default: ;
    endcase
  end

  // State, context and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wstrb_q    <= '0;
      wdata_q    <= '0;
      row_open_q <= 1'b0;
      open_row_q <= '0;
      close_q    <= 1'b0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      DRAM_CSn   <= 1'b1;
      DRAM_RASn  <= 1'b1;
      DRAM_CASn  <= 1'b1;
      DRAM_WEn   <= 4'hF;
      DRAM_A     <= '0;
      DRAM_D     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wstrb_q    <= wstrb_d;
      wdata_q    <= wdata_d;
      row_open_q <= row_open_d;
      open_row_q <= open_row_d;
      close_q    <= close_d;
      req_ready  <= (state_d == S_IDLE);
      resp_valid <= (state_d == S_RESP);
      resp_rdata <= rdata_d;
      resp_err   <= err_d;
      DRAM_CSn   <= csn_d;
      DRAM_RASn  <= rasn_d;
      DRAM_CASn  <= casn_d;
      DRAM_WEn   <= wen_d;
      DRAM_A     <= a_d;
      DRAM_D     <= d_d;
    end
  end

endmodule

// File: tb/tb_dram_page_ctrl.sv
// Directed bench for dram_page_ctrl with default timings and IDLE_CLOSE=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dram_page_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [20:0] req_addr;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        DRAM_CSn;
  logic        DRAM_RASn;
  logic        DRAM_CASn;
  logic [3:0]  DRAM_WEn;
  logic [10:0] DRAM_A;
  logic [31:0] DRAM_D;
  logic [31:0] DRAM_Q;
  logic        DRAM_valid;

  int checks   = 0;
  int failures = 0;

  dram_page_ctrl #(
    .T_RP(5), .T_RCD(5), .T_WR(5), .RD_TIMEOUT(64), .IDLE_CLOSE(8)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .DRAM_CSn(DRAM_CSn), .DRAM_RASn(DRAM_RASn), .DRAM_CASn(DRAM_CASn),
    .DRAM_WEn(DRAM_WEn), .DRAM_A(DRAM_A), .DRAM_D(DRAM_D),
    .DRAM_Q(DRAM_Q), .DRAM_valid(DRAM_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_pins(input string tag, input logic rasn, input logic casn,
                          input logic [3:0] wen);
    chk({tag, " csn"}, 32'(DRAM_CSn), 32'(1'b0));
    chk({tag, " rasn"}, 32'(DRAM_RASn), 32'(rasn));
    chk({tag, " casn"}, 32'(DRAM_CASn), 32'(casn));
    chk({tag, " wen"}, 32'(DRAM_WEn), 32'(wen));
  endtask

  // Presents a request in the current cycle; returns at the falling edge of T+1.
  task automatic issue(input string tag, input logic wr, input logic [20:0] addr,
                       input logic [3:0] strb, input logic [31:0] data);
    chk({tag, " ready"}, 32'(req_ready), 32'(1'b1));
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wstrb = strb;
    req_wdata = data;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic dram_return(input logic [31:0] q);
    DRAM_valid = 1'b1;
    DRAM_Q     = q;
    wait_cyc(1);
    DRAM_valid = 1'b0;
    DRAM_Q     = '0;
  endtask

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wstrb = '0; req_wdata = '0; DRAM_Q = '0; DRAM_valid = 1'b0;

    // Reset values
    wait_cyc(3);
    chk("rst ready", 32'(req_ready), 32'(1'b0));
    chk("rst resp_valid", 32'(resp_valid), 32'(1'b0));
    chk("rst rdata", resp_rdata, 32'h0);
    chk("rst err", 32'(resp_err), 32'(1'b0));
    chk("rst csn", 32'(DRAM_CSn), 32'(1'b1));
    chk("rst rasn", 32'(DRAM_RASn), 32'(1'b1));
    chk("rst casn", 32'(DRAM_CASn), 32'(1'b1));
    chk("rst wen", 32'(DRAM_WEn), 32'hF);
    chk("rst a", 32'(DRAM_A), 32'h0);
    chk("rst d", DRAM_D, 32'h0);
    rstn = 1'b1;
    wait_cyc(1);
    chk_pins("post-rst nop", 1'b1, 1'b1, 4'hF);

    // Closed-row read of 0x00405: ACT at T+1, RD at T+6, valid at T+9, resp at T+10
    issue("t1", 1'b0, 21'h00405, 4'h0, 32'h0);
    chk_pins("t1 act", 1'b0, 1'b1, 4'hF);
    chk("t1 act a", 32'(DRAM_A), 32'h1);
    wait_cyc(4);
    chk_pins("t1 act_w nop", 1'b1, 1'b1, 4'hF);
    wait_cyc(1);
    chk_pins("t1 rd", 1'b1, 1'b0, 4'hF);
    chk("t1 rd a", 32'(DRAM_A), 32'h5);
    wait_cyc(3);
    chk("t1 no early resp", 32'(resp_valid), 32'(1'b0));
    dram_return(32'hDEADBEEF);
    chk("t1 resp_valid", 32'(resp_valid), 32'(1'b1));
    chk("t1 rdata", resp_rdata, 32'hDEADBEEF);
    chk("t1 err", 32'(resp_err), 32'(1'b0));
    wait_cyc(1);
    chk("t1 resp one cycle", 32'(resp_valid), 32'(1'b0));
    chk("t1 rdata hold", resp_rdata, 32'hDEADBEEF);

    // Page-hit write 0x00406: WR at T+1, resp at T+6
    issue("t2", 1'b1, 21'h00406, 4'b0101, 32'h11223344);
    chk_pins("t2 wr", 1'b1, 1'b0, 4'b1010);
    chk("t2 wr a", 32'(DRAM_A), 32'h6);
    chk("t2 wr d", DRAM_D, 32'h11223344);
    wait_cyc(1);
    chk_pins("t2 wr_w nop", 1'b1, 1'b1, 4'hF);
    wait_cyc(3);
    chk("t2 no early resp", 32'(resp_valid), 32'(1'b0));
    wait_cyc(1);
    chk("t2 resp_valid", 32'(resp_valid), 32'(1'b1));
    chk("t2 err", 32'(resp_err), 32'(1'b0));
    wait_cyc(1);

    // Row miss read 0x00C00: PRE T+1, ACT A=3 T+6, RD A=0 T+11
    issue("t3", 1'b0, 21'h00C00, 4'h0, 32'h0);
    chk_pins("t3 pre", 1'b0, 1'b1, 4'h0);
    wait_cyc(5);
    chk_pins("t3 act", 1'b0, 1'b1, 4'hF);
    chk("t3 act a", 32'(DRAM_A), 32'h3);
    wait_cyc(5);
    chk_pins("t3 rd", 1'b1, 1'b0, 4'hF);
    chk("t3 rd a", 32'(DRAM_A), 32'h0);
    wait_cyc(1);
    dram_return(32'h0BADF00D);
    chk("t3 resp_valid", 32'(resp_valid), 32'(1'b1));
    chk("t3 rdata", resp_rdata, 32'h0BADF00D);
    wait_cyc(1);

    // Read timeout on a page hit: RD_W entered at T+2, error response at T+66
    issue("t4", 1'b0, 21'h00C07, 4'h0, 32'h0);
    chk_pins("t4 rd hit", 1'b1, 1'b0, 4'hF);
    chk("t4 rd a", 32'(DRAM_A), 32'h7);
    wait_cyc(64);
    chk("t4 no early timeout", 32'(resp_valid), 32'(1'b0));
    wait_cyc(1);
    chk("t4 resp_valid", 32'(resp_valid), 32'(1'b1));
    chk("t4 err", 32'(resp_err), 32'(1'b1));
    chk("t4 rdata zero", resp_rdata, 32'h0);
    wait_cyc(1);
    // A late valid while idle must not produce a response
    dram_return(32'hFFFFFFFF);
    chk("t4 late valid ignored", 32'(resp_valid), 32'(1'b0));

    // Same row still open after the timeout: page hit
    issue("t5", 1'b0, 21'h00C08, 4'h0, 32'h0);
    chk_pins("t5 rd hit", 1'b1, 1'b0, 4'hF);
    chk("t5 rd a", 32'(DRAM_A), 32'h8);
    wait_cyc(1);
    dram_return(32'h55AA55AA);
    chk("t5 resp_valid", 32'(resp_valid), 32'(1'b1));
    chk("t5 rdata", resp_rdata, 32'h55AA55AA);
    chk("t5 err clear", 32'(resp_err), 32'(1'b0));

    // Idle close: IDLE from T+4, PRE on the 9th idle cycle, back to IDLE after PRE_W
    wait_cyc(8);
    chk_pins("t6 8th idle nop", 1'b1, 1'b1, 4'hF);
    chk("t6 8th idle ready", 32'(req_ready), 32'(1'b1));
    wait_cyc(1);
    chk_pins("t6 close pre", 1'b0, 1'b1, 4'h0);
    chk("t6 pre not ready", 32'(req_ready), 32'(1'b0));
    wait_cyc(4);
    chk("t6 pre_w not ready", 32'(req_ready), 32'(1'b0));
    wait_cyc(1);
    chk("t6 back idle", 32'(req_ready), 32'(1'b1));
    chk("t6 no resp", 32'(resp_valid), 32'(1'b0));

    // After close the old row needs ACT again
    issue("t7", 1'b0, 21'h00C09, 4'h0, 32'h0);
    chk_pins("t7 act", 1'b0, 1'b1, 4'hF);
    chk("t7 act a", 32'(DRAM_A), 32'h3);
    wait_cyc(5);
    chk_pins("t7 rd", 1'b1, 1'b0, 4'hF);
    chk("t7 rd a", 32'(DRAM_A), 32'h9);
    wait_cyc(1);
    dram_return(32'h12345678);
    chk("t7 resp_valid", 32'(resp_valid), 32'(1'b1));
    chk("t7 rdata", resp_rdata, 32'h12345678);

    // Request in the expiry cycle (8th idle cycle) wins: page hit, no PRE
    wait_cyc(8);
    issue("t8", 1'b0, 21'h00C0A, 4'h0, 32'h0);
    chk_pins("t8 rd hit", 1'b1, 1'b0, 4'hF);
    chk("t8 rd a", 32'(DRAM_A), 32'hA);
    wait_cyc(1);
    dram_return(32'hCAFEF00D);
    chk("t8 resp_valid", 32'(resp_valid), 32'(1'b1));
    chk("t8 rdata", resp_rdata, 32'hCAFEF00D);
    wait_cyc(1);

    // Zero-strobe write: no command, resp at T+1
    issue("t9", 1'b1, 21'h1FFFFF, 4'h0, 32'hFFFFFFFF);
    chk("t9 resp_valid", 32'(resp_valid), 32'(1'b1));
    chk_pins("t9 no cmd", 1'b1, 1'b1, 4'hF);
    chk("t9 err", 32'(resp_err), 32'(1'b0));
    wait_cyc(1);

    // Reset during ACT_W of a row-miss write aborts with no response
    issue("t10", 1'b1, 21'h01401, 4'hF, 32'h9ABCDEF0);
    chk_pins("t10 pre", 1'b0, 1'b1, 4'h0);
    wait_cyc(5);
    chk_pins("t10 act", 1'b0, 1'b1, 4'hF);
    chk("t10 act a", 32'(DRAM_A), 32'h5);
    wait_cyc(2);
    rstn = 1'b0;
    #1;
    chk("t10 rst csn", 32'(DRAM_CSn), 32'(1'b1));
    chk("t10 rst rasn", 32'(DRAM_RASn), 32'(1'b1));
    chk("t10 rst casn", 32'(DRAM_CASn), 32'(1'b1));
    chk("t10 rst wen", 32'(DRAM_WEn), 32'hF);
    chk("t10 rst a", 32'(DRAM_A), 32'h0);
    chk("t10 rst ready", 32'(req_ready), 32'(1'b0));
    wait_cyc(2);
    rstn = 1'b1;
    wait_cyc(1);
    chk("t10 no resp", 32'(resp_valid), 32'(1'b0));
    chk("t10 ready", 32'(req_ready), 32'(1'b1));

    // No row open after reset: ACT first
    issue("t11", 1'b0, 21'h01402, 4'h0, 32'h0);
    chk_pins("t11 act", 1'b0, 1'b1, 4'hF);
    chk("t11 act a", 32'(DRAM_A), 32'h5);
    wait_cyc(5);
    chk_pins("t11 rd", 1'b1, 1'b0, 4'hF);
    chk("t11 rd a", 32'(DRAM_A), 32'h2);
    wait_cyc(1);
    dram_return(32'hA5A5A5A5);
    chk("t11 resp_valid", 32'(resp_valid), 32'(1'b1));
    chk("t11 rdata", resp_rdata, 32'hA5A5A5A5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
